// File: rtl/muldiv_unit.sv
// muldiv_unit: shared iterative signed/unsigned multiply and restoring divide,
// one radix-2 step per cycle, with results delivered to hi/lo on done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2*WIDTH-1:0]   acc, acc_n;
    logic [WIDTH-1:0]     m, m_n, hi_n, lo_n;
    logic                 is_div, is_div_n, neg_q, neg_q_n, neg_r, neg_r_n;
    logic                 dz, dz_n, done_n, div_zero_n;

    logic                 sa, sb, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem;

    assign sa     = ~op[0] & a[WIDTH-1];
    assign sb     = ~op[0] & b[WIDTH-1];
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;
    assign b_zero = op[1] && (b == '0);

    // acc = {partial product, remaining multiplier bits}; the sum keeps its carry
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits shifting into quotient bits}
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, m};
    assign div_next = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~diff[WIDTH]};

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            m        <= m_n;
            is_div   <= is_div_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            dz       <= dz_n;
            hi       <= hi_n;
            lo       <= lo_n;
            done     <= done_n;
            div_zero <= div_zero_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        acc_n      = acc;
        m_n        = m;
        is_div_n   = is_div;
        neg_q_n    = neg_q;
        neg_r_n    = neg_r;
        dz_n       = dz;
        hi_n       = hi;
        lo_n       = lo;
        done_n     = 1'b0;
        div_zero_n = 1'b0;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    is_div_n = op[1];
                    neg_q_n  = sa ^ sb;
                    neg_r_n  = sa;
                    dz_n     = b_zero;
                    m_n      = op[1] ? mag_b : mag_a;
                    cnt_n    = CNT_W'(WIDTH);
                    // a zero divisor skips the iterations and parks the raw result in acc
                    acc_n    = b_zero ? {a, {WIDTH{1'b1}}}
                             : {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    state_n  = b_zero ? FIX : CALC;
                end
                CALC: begin
                    acc_n   = is_div ? div_next : mul_next;
                    cnt_n   = cnt - 1'b1;
                    state_n = (cnt == CNT_W'(1)) ? FIX : CALC;
                end
                FIX: begin
                    state_n      = IDLE;
                    done_n       = 1'b1;
                    div_zero_n   = dz;
                    {hi_n, lo_n} = dz ? acc : is_div ? {rem, quo} : prod;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for the 32-bit and 8-bit muldiv_unit instances.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start32 = 1'b0, flush32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;
    int          n_chk = 0, n_pass = 0;

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .flush(flush32), .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // lat counts negedges from the accept edge until done is seen (accept edge = 1)
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; op32 = o ^ 2'b01; a32 = ~x;
        lat = 1;
        while (!done32 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, t, n_done;
        repeat (2) @(negedge clk);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_hilo", {hi32, lo32}, 0);
        reset = 1'b1;

        run32(2'b00, 32'hFFFF_FFFD, 32'd5, lat);
        check("mult_lat", lat, 34);
        check("mult_hi", hi32, 32'hFFFF_FFFF);
        check("mult_lo", lo32, 32'hFFFF_FFF1);
        check("mult_dz", dz32, 0);

        run32(2'b01, 32'hFFFF_FFFF, 32'd2, lat);
        check("multu_hi", hi32, 32'h0000_0001);
        check("multu_lo", lo32, 32'hFFFF_FFFE);

        run32(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lo", lo32, 32'hFFFF_FFFD);
        check("div_hi", hi32, 32'hFFFF_FFFF);

        run32(2'b11, 32'd100, 32'd7, lat);
        check("divu_lo", lo32, 14);
        check("divu_hi", hi32, 2);

        run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_lo", lo32, 32'h8000_0000);
        check("ovf_hi", hi32, 0);
        check("ovf_dz", dz32, 0);

        run32(2'b11, 32'd100, 32'd0, lat);
        check("dz_lat", lat, 2);
        check("dz_flag", dz32, 1);
        check("dz_hi", hi32, 100);
        check("dz_lo", lo32, 32'hFFFF_FFFF);
        @(negedge clk);
        check("dz_busy_after", busy32, 0);
        check("dz_flag_pulse", dz32, 0);
        check("dz_done_pulse", done32, 0);

        // start pulsed mid-CALC must be ignored
        op32 = 2'b01; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        op32 = 2'b00; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        t = 0;
        while (!done32 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ign_timeout", t < 100, 1);
        check("ign_lo", lo32, 12);
        check("ign_hi", hi32, 0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) n_done++;
        end
        check("ign_extra_done", n_done, 0);

        // start held through done: second op accepted back-to-back
        op32 = 2'b01; a32 = 32'd6; b32 = 32'd7; start32 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done32 && t < 100);
        check("b2b_first", lo32, 42);
        a32 = 32'd5; b32 = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        check("b2b_busy", busy32, 1);
        lat = 1;
        while (!done32 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", lat, 34);
        check("b2b_lo", lo32, 25);

        // flush at cycle 10 aborts silently
        @(negedge clk);
        op32 = 2'b01; a32 = 32'h1234; b32 = 32'h10; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        check("flush_busy", busy32, 0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) n_done++;
        end
        check("flush_no_done", n_done, 0);
        check("flush_hilo", {hi32, lo32}, {32'd0, 32'd25});

        // asynchronous reset between edges mid-CALC
        op32 = 2'b01; a32 = 32'd11; b32 = 32'd13; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy32, 0);
        check("arst_done", done32, 0);
        check("arst_hilo", {hi32, lo32}, 0);
        @(negedge clk);
        reset = 1'b1;
        run32(2'b01, 32'd6, 32'd7, lat);
        check("post_rst_lo", lo32, 42);
        check("post_rst_hi", hi32, 0);

        run8(2'b00, 8'h80, 8'h80, lat);
        check("w8_mult_lat", lat, 10);
        check("w8_mult_hi", hi8, 8'h40);
        check("w8_mult_lo", lo8, 8'h00);
        run8(2'b10, 8'h81, 8'h03, lat);
        check("w8_div_lo", lo8, 8'hD6);
        check("w8_div_hi", hi8, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine; replaces the separate fixed-32-bit mult and div blocks in the multicycle datapath with one shared unit.
- Supports signed and unsigned multiply and divide at any WIDTH.
- Uses a start/busy/done handshake, a flush input and a divide-by-zero flag.
- Results go to the HI/LO registers under control-unit sequencing.

Parameters:
- WIDTH, 32, operand width in bits (legal range 4..64); hi/lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  multiplicand / dividend; captured on the accepted start.
- b  input  WIDTH  multiplier / divisor; captured on the accepted start.
- flush  input  1  synchronous abort; returns to IDLE with no done.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo valid.
- div_zero  output  1  pulses with done when a DIV/DIVU has b==0.
- hi  output  WIDTH  MULT: upper product half; DIV: remainder.
- lo  output  WIDTH  MULT: lower product half; DIV: quotient.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, all internal registers 0.
- FSM states: IDLE, CALC, FIX.
  - IDLE→CALC on start=1. Edge k captures a, b, op and the operand signs. Signed ops store magnitudes; counter loads WIDTH.
  - IDLE→FIX instead when op is DIV/DIVU and b==0.
  - CALC: one radix-2 step per cycle, counter decrements; CALC→FIX when counter reaches 1 at that edge, giving exactly WIDTH CALC cycles.
    - Multiply: shift-add over a 2*WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - FIX→IDLE always. At this edge: apply sign correction, register hi/lo, set done=1 (and div_zero when applicable).
- Latency with start accepted at edge k: busy=1 from after k until after edge k+WIDTH+1. Normal ops: done=1 in the cycle after edge k+WIDTH+1. Divide-by-zero: done after edge k+1.
- done and div_zero are high for exactly one cycle. hi/lo hold their values until the next done, and are not disturbed by flush or by a new start.
- Signed multiply: full 2*WIDTH two's-complement product.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Quotient is negated iff the operand signs differ.
  - Most-negative / -1 gives lo = most-negative value, hi = 0, with no flag.
- Divide by zero: hi = a (as given), lo = all-ones, div_zero=1.
- start while busy is ignored; it is neither queued nor latched. start in the same cycle as done is accepted, since the FSM is already in IDLE.
- flush=1 in CALC or FIX → IDLE at the next edge; busy=0, no done, hi/lo unchanged. flush has priority over start in IDLE.
- Reset mid-operation: immediate return to the reset values; no done.
- An op change after the accepted start has no effect.

Test Plan (WIDTH=32 unless noted):
1. MULT a=0xFFFFFFFD (-3), b=5 → done exactly 34 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
3. DIVU a=100, b=0 → done and div_zero high together, 2 cycles after start; hi=100, lo=0xFFFFFFFF; busy low afterwards.
4. Restart and aborts:
   - start pulsed mid-CALC → ignored; a single done with the first op's result.
   - start held high through done → second op accepted back-to-back.
   - flush at cycle 10 → no done, previous hi/lo retained.
5. reset driven low asynchronously mid-CALC (between edges) → busy/done/hi/lo are 0 immediately. After release, MULTU 6×7 → lo=42, hi=0.
6. WIDTH=8 instance: MULT 0x80×0x80 → hi=0x40, lo=0x00, done 10 cycles after start. DIV 0x81 (-127) / 0x03 → lo=0xD6 (-42), hi=0xFF (-1).
